// File: rtl/alu_cmd_sequencer_pkg.sv
// Shared definitions for the super-ALU command sequencer: op-codes, alu_type
// one-hot codes, FSM state encoding and the command record width.
package alu_cmd_sequencer_pkg;

    localparam logic [1:0] OP_MUL  = 2'b00;
    localparam logic [1:0] OP_DIV  = 2'b01;
    localparam logic [1:0] OP_SQRT = 2'b10;
    localparam logic [1:0] OP_ILL  = 2'b11;

    // alu_type is {MUL, DIV, SQRT, 1'b0}
    localparam logic [3:0] TYPE_MUL  = 4'b1000;
    localparam logic [3:0] TYPE_DIV  = 4'b0100;
    localparam logic [3:0] TYPE_SQRT = 4'b0010;
    localparam logic [3:0] TYPE_NONE = 4'b0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    // op + mode + x + y + offset + tag
    function automatic int cmd_width(input int max_w, input int off_w);
        return 2 + 2 + max_w + max_w + off_w + 2;
    endfunction

    localparam int CMD_W = cmd_width(13, 10);

    function automatic logic [3:0] type_of(input logic [1:0] op);
        logic [3:0] t;
        case (op)
            OP_MUL:  t = TYPE_MUL;
            OP_DIV:  t = TYPE_DIV;
            OP_SQRT: t = TYPE_SQRT;
            default: t = TYPE_NONE;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/alu_cmd_sequencer_cmd_fifo.sv
// Synchronous FIFO for command records; occupancy tracked with an extra
// pointer bit so full and empty are distinguishable when the indices match.
module cmd_fifo #(
    parameter int WIDTH = 42,
    parameter int DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_data    = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // storage needs no reset; the pointers define what is valid
    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Command front-end for the shared super-ALU: queues requests, issues them one
// at a time with a start-low gap and timeout, and returns results in order.
module alu_cmd_sequencer
    import alu_cmd_sequencer_pkg::*;
#(
    parameter int MAX_WIDTH    = 13,
    parameter int OFFSET_WIDTH = 10,
    parameter int FIFO_DEPTH   = 4,
    parameter int GAP_CYCLES   = 2,
    parameter int TIMEOUT      = 1023
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [1:0]              cmd_op,
    input  logic [1:0]              cmd_mode,
    input  logic [MAX_WIDTH-1:0]    cmd_x,
    input  logic [MAX_WIDTH-1:0]    cmd_y,
    input  logic [OFFSET_WIDTH-1:0] cmd_offset,
    input  logic [1:0]              cmd_tag,
    output logic [MAX_WIDTH-1:0]    alu_x,
    output logic [MAX_WIDTH-1:0]    alu_y,
    output logic [OFFSET_WIDTH-1:0] alu_offset,
    output logic [1:0]              alu_mode,
    output logic [3:0]              alu_type,
    output logic                    alu_start,
    input  logic [MAX_WIDTH-1:0]    alu_fout,
    input  logic [MAX_WIDTH-1:0]    alu_pout,
    input  logic                    alu_done,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [MAX_WIDTH-1:0]    res_fout,
    output logic [MAX_WIDTH-1:0]    res_pout,
    output logic [1:0]              res_tag,
    output logic                    res_err
);

    localparam int CW = cmd_width(MAX_WIDTH, OFFSET_WIDTH);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    state_t                  r_state;
    state_t                  w_next;
    logic [TW-1:0]           r_tmo;
    logic [GW-1:0]           r_gap;
    logic [1:0]              r_tag;

    logic                    w_full;
    logic                    w_empty;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_load;
    logic                    w_illegal;
    logic                    w_capture;
    logic                    w_timeout;
    logic                    w_slot_free;
    logic [CW-1:0]           w_head;
    logic [1:0]              w_head_op;
    logic [1:0]              w_head_mode;
    logic [MAX_WIDTH-1:0]    w_head_x;
    logic [MAX_WIDTH-1:0]    w_head_y;
    logic [OFFSET_WIDTH-1:0] w_head_off;
    logic [1:0]              w_head_tag;

    assign cmd_ready   = !w_full && !RST;
    assign w_push      = cmd_valid && cmd_ready;
    assign w_slot_free = !res_valid || res_ready;
    assign {w_head_op, w_head_mode, w_head_x, w_head_y, w_head_off, w_head_tag} = w_head;

    cmd_fifo #(
        .WIDTH (CW),
        .DEPTH (FIFO_DEPTH)
    ) u_cmd_fifo (
        .i_clk   (CLK),
        .i_rst   (RST),
        .i_push  (w_push),
        .i_data  ({cmd_op, cmd_mode, cmd_x, cmd_y, cmd_offset, cmd_tag}),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge CLK) begin
        if (RST) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        w_pop     = 1'b0;
        w_load    = 1'b0;
        w_illegal = 1'b0;
        w_capture = 1'b0;
        w_timeout = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty && w_slot_free) begin
                    w_pop = 1'b1;
                    // illegal ops never touch the ALU and are answered in place
                    if (w_head_op == OP_ILL) begin
                        w_illegal = 1'b1;
                    end else begin
                        w_load = 1'b1;
                        w_next = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: w_next = ST_WAIT;
            ST_WAIT: begin
                if (alu_done) begin
                    w_capture = 1'b1;
                    w_next    = ST_GAP;
                end else if (r_tmo == TW'(TIMEOUT)) begin
                    w_timeout = 1'b1;
                    w_next    = ST_GAP;
                end
            end
            ST_GAP: begin
                if (r_gap == GW'(GAP_CYCLES - 1)) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            alu_x      <= '0;
            alu_y      <= '0;
            alu_offset <= '0;
            alu_mode   <= '0;
            alu_type   <= TYPE_NONE;
            alu_start  <= 1'b0;
            r_tag      <= '0;
            r_tmo      <= '0;
            r_gap      <= '0;
        end else begin
            if (w_load) begin
                alu_x      <= w_head_x;
                alu_y      <= w_head_y;
                alu_offset <= w_head_off;
                alu_mode   <= w_head_mode;
                alu_type   <= type_of(w_head_op);
                r_tag      <= w_head_tag;
            end
            // start is high exactly while the FSM sits in WAIT
            alu_start <= (w_next == ST_WAIT);
            if (r_state == ST_ISSUE)                          r_tmo <= '0;
            else if (r_state == ST_WAIT && r_tmo != TW'(TIMEOUT)) r_tmo <= r_tmo + 1'b1;
            if (r_state == ST_GAP) r_gap <= r_gap + 1'b1;
            else                   r_gap <= '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            res_valid <= 1'b0;
            res_fout  <= '0;
            res_pout  <= '0;
            res_tag   <= '0;
            res_err   <= 1'b0;
        end else if (w_capture) begin
            res_valid <= 1'b1;
            res_fout  <= alu_fout;
            res_pout  <= alu_pout;
            res_tag   <= r_tag;
            res_err   <= 1'b0;
        end else if (w_timeout || w_illegal) begin
            res_valid <= 1'b1;
            res_fout  <= '0;
            res_pout  <= '0;
            res_tag   <= w_illegal ? w_head_tag : r_tag;
            res_err   <= 1'b1;
        end else if (res_valid && res_ready) begin
            res_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench for alu_cmd_sequencer: stub ALU, in-order result model,
// directed scenarios and a randomized command stream.
module tb_alu_cmd_sequencer;

    localparam int MW    = 13;
    localparam int OW    = 10;
    localparam int DEPTH = 4;
    localparam int GAP   = 2;
    localparam int TMO   = 15;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [1:0]    cmd_op = '0, cmd_mode = '0, cmd_tag = '0;
    logic [MW-1:0] cmd_x = '0, cmd_y = '0;
    logic [OW-1:0] cmd_offset = '0;
    logic [MW-1:0] alu_x, alu_y, alu_fout, alu_pout;
    logic [OW-1:0] alu_offset;
    logic [1:0]    alu_mode;
    logic [3:0]    alu_type;
    logic          alu_start, alu_done;
    logic          res_valid, res_ready = 1'b0;
    logic [MW-1:0] res_fout, res_pout;
    logic [1:0]    res_tag;
    logic          res_err;

    alu_cmd_sequencer #(
        .MAX_WIDTH(MW), .OFFSET_WIDTH(OW), .FIFO_DEPTH(DEPTH),
        .GAP_CYCLES(GAP), .TIMEOUT(TMO)
    ) dut (
        .CLK(CLK), .RST(RST), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_mode(cmd_mode), .cmd_x(cmd_x), .cmd_y(cmd_y),
        .cmd_offset(cmd_offset), .cmd_tag(cmd_tag),
        .alu_x(alu_x), .alu_y(alu_y), .alu_offset(alu_offset), .alu_mode(alu_mode),
        .alu_type(alu_type), .alu_start(alu_start),
        .alu_fout(alu_fout), .alu_pout(alu_pout), .alu_done(alu_done),
        .res_valid(res_valid), .res_ready(res_ready), .res_fout(res_fout),
        .res_pout(res_pout), .res_tag(res_tag), .res_err(res_err)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [MW-1:0] f;
        logic [MW-1:0] p;
        logic [1:0]    tag;
        logic          err;
    } res_t;

    typedef struct packed {
        logic [MW-1:0] x;
        logic [MW-1:0] y;
        logic [OW-1:0] off;
        logic [1:0]    mode;
        logic [3:0]    typ;
    } iss_t;

    res_t exp_q[$];
    iss_t iss_q[$];
    res_t got_q[$];
    int   gap_q[$];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int done_cyc = 0;
    int n_starts = 0;
    int rdy_mode = 0;
    bit chk_en = 0;
    bit never_done = 0;
    bit spur = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Stub ALU: random latency, result = {x^y, x+y} only in the done cycle.
    initial begin : stub_alu
        bit busy, given;
        int cnt;
        busy = 0; given = 0; cnt = 0;
        alu_done = 1'b0; alu_fout = '0; alu_pout = '0;
        forever begin
            @(negedge CLK);
            alu_done = 1'b0;
            alu_fout = MW'($urandom);
            alu_pout = MW'($urandom);
            if (!alu_start) begin
                busy = 0; given = 0;
                if (spur) begin alu_done = 1'b1; spur = 0; end
            end else begin
                if (!busy) begin busy = 1; cnt = $urandom_range(0, 4); end
                if (!given) begin
                    if (cnt == 0 && !never_done) begin
                        alu_done = 1'b1;
                        given    = 1;
                        alu_fout = alu_x ^ alu_y;
                        alu_pout = alu_x + alu_y;
                        done_cyc = cyc;
                    end else if (cnt > 0) begin
                        cnt--;
                    end
                end
            end
        end
    end

    // Compare process: issue fields, start spacing, and every visible result.
    initial begin : compare
        bit prev_start, had_prior;
        int low_len, high_len;
        iss_t it;
        res_t e;
        prev_start = 0; had_prior = 0; low_len = 0; high_len = 0;
        forever begin
            @(negedge CLK);
            case (rdy_mode)
                0:       res_ready = 1'b0;
                1:       res_ready = 1'b1;
                default: res_ready = 1'($urandom_range(0, 1));
            endcase
            #1;
            if (alu_start && !prev_start) begin
                n_starts++;
                gap_q.push_back(low_len);
                if (chk_en) begin
                    if (iss_q.size() == 0) begin
                        chk("spurious_start", 1, 0);
                    end else begin
                        it = iss_q.pop_front();
                        chk("issue", {alu_x, alu_y, alu_offset, alu_mode, alu_type}, it);
                    end
                    if (had_prior) chk("start_gap_min", 64'(low_len >= GAP + 2), 1);
                end
                high_len = 1;
            end else if (alu_start) begin
                high_len++;
            end else if (prev_start) begin
                if (chk_en && never_done) chk("timeout_len", high_len, TMO + 1);
                low_len = 1;
                had_prior = 1;
            end else begin
                low_len++;
            end
            prev_start = alu_start;
            if (chk_en && res_valid) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_result", 1, 0);
                end else begin
                    e = exp_q[0];
                    chk("result", {res_fout, res_pout, res_tag, res_err}, e);
                    if (res_ready) begin
                        void'(exp_q.pop_front());
                        got_q.push_back({res_fout, res_pout, res_tag, res_err});
                    end
                end
            end
        end
    end

    task automatic push(input logic [1:0] op, input logic [1:0] mode, input logic [MW-1:0] x,
                        input logic [MW-1:0] y, input logic [OW-1:0] off, input logic [1:0] tag,
                        output bit acc);
        logic [MW-1:0] s;
        @(negedge CLK);
        cmd_valid = 1'b1; cmd_op = op; cmd_mode = mode;
        cmd_x = x; cmd_y = y; cmd_offset = off; cmd_tag = tag;
        #1 acc = cmd_ready;
        if (acc) begin
            s = x + y;
            if (op == 2'b11)     exp_q.push_back({MW'(0), MW'(0), tag, 1'b1});
            else if (never_done) exp_q.push_back({MW'(0), MW'(0), tag, 1'b1});
            else                 exp_q.push_back({x ^ y, s, tag, 1'b0});
            if (op != 2'b11) iss_q.push_back({x, y, off, mode, 4'b1000 >> op});
        end
        @(posedge CLK);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_for(input int sel, input int maxc, input string name);
        int n;
        n = 0;
        do begin
            @(negedge CLK);
            #2;
            n++;
        end while (!((sel == 0) ? alu_start : res_valid) && n < maxc);
        if (n >= maxc) chk({name, "_wait_timeout"}, 0, 1);
    endtask

    task automatic drain(input int maxc, input string name);
        int n;
        n = 0;
        do begin
            @(negedge CLK);
            #2;
            n++;
        end while ((exp_q.size() != 0 || res_valid) && n < maxc);
        if (n >= maxc) chk({name, "_drain_timeout"}, exp_q.size(), 0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        bit acc;
        int p, s, nacc, sc;
        // reset state
        repeat (3) @(posedge CLK);
        @(negedge CLK); #1;
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_alu_start", alu_start, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_alu_type", alu_type, 0);
        chk("rst_alu_data", {alu_x, alu_y, alu_offset, alu_mode}, 0);
        chk("rst_res_data", {res_fout, res_pout, res_tag, res_err}, 0);
        RST = 1'b0;
        chk_en = 1;
        @(negedge CLK); #1;
        chk("post_rst_ready", cmd_ready, 1);

        // MUL: latency and literal result
        rdy_mode = 1;
        push(2'b00, 2'b00, 13'd240, 13'd107, 10'd0, 2'd1, acc);
        p = cyc;
        chk("mul_accept", acc, 1);
        wait_for(0, 20, "mul_start");
        chk("mul_issue_latency", cyc - p, 2);
        chk("mul_type", alu_type, 4'b1000);
        wait_for(1, 40, "mul_result");
        chk("mul_res_latency", cyc - done_cyc, 1);
        chk("mul_fout", res_fout, 155);
        chk("mul_pout", res_pout, 347);
        chk("mul_err", res_err, 0);
        drain(50, "mul");

        // DIV back-to-back: order, tags and minimum start spacing
        got_q.delete(); gap_q.delete();
        push(2'b01, 2'b01, 13'd42, 13'd27, 10'd5, 2'd2, acc);
        push(2'b01, 2'b10, 13'd142, 13'd270, 10'd9, 2'd3, acc);
        drain(100, "div");
        chk("div_count", got_q.size(), 2);
        chk("div_first", (got_q.size() >= 1) ? {got_q[0].f, got_q[0].tag} : 0, {13'd49, 2'd2});
        chk("div_second", (got_q.size() >= 2) ? {got_q[1].f, got_q[1].tag} : 0, {13'd384, 2'd3});
        chk("b2b_gap", (gap_q.size() >= 2) ? gap_q[1] : 0, GAP + 2);

        // Backpressure: fill FIFO behind a held result
        rdy_mode = 0;
        nacc = 0;
        for (int i = 0; i < 8; i++) begin
            push(2'($urandom_range(0, 2)), 2'($urandom), MW'($urandom), MW'($urandom),
                 OW'($urandom), 2'(i), acc);
            if (!acc) break;
            nacc++;
        end
        chk("bp_accepted", nacc, DEPTH + 1);
        repeat (10) @(negedge CLK);
        #2 chk("bp_ready_low", cmd_ready, 0);
        chk("bp_held_valid", res_valid, 1);
        rdy_mode = 1;
        drain(300, "bp");

        // Illegal op with a stray done while idle
        sc = n_starts;
        spur = 1;
        repeat (3) @(negedge CLK);
        push(2'b11, 2'b00, 13'd77, 13'd88, 10'd1, 2'd2, acc);
        wait_for(1, 20, "ill_result");
        chk("ill_result", {res_fout, res_pout, res_tag, res_err}, {13'd0, 13'd0, 2'd2, 1'b1});
        drain(50, "ill");
        repeat (5) @(negedge CLK);
        chk("ill_no_start", n_starts - sc, 0);

        // Timeout, then a normal command
        never_done = 1;
        push(2'b00, 2'b00, 13'd3, 13'd4, 10'd0, 2'd1, acc);
        wait_for(0, 20, "tmo_start");
        s = cyc;
        wait_for(1, 60, "tmo_result");
        chk("tmo_latency", cyc - s, TMO + 1);
        chk("tmo_result", {res_fout, res_pout, res_err}, {13'd0, 13'd0, 1'b1});
        drain(50, "tmo");
        never_done = 0;
        push(2'b10, 2'b11, 13'd100, 13'd200, 10'd7, 2'd0, acc);
        drain(50, "post_tmo");

        // Randomized stream with random result backpressure
        rdy_mode = 2;
        for (int i = 0; i < 80; i++) begin
            push(2'($urandom), 2'($urandom), MW'($urandom), MW'($urandom),
                 OW'($urandom), 2'($urandom), acc);
            repeat ($urandom_range(0, 3)) @(negedge CLK);
        end
        drain(3000, "rand");

        // Reset in WAIT
        rdy_mode = 1;
        never_done = 1;
        push(2'b00, 2'b01, 13'd11, 13'd12, 10'd0, 2'd3, acc);
        wait_for(0, 20, "rst_start");
        repeat (3) @(negedge CLK);
        chk_en = 0;
        RST = 1'b1;
        @(posedge CLK);
        #1;
        chk("rst_wait_start", alu_start, 0);
        chk("rst_wait_valid", res_valid, 0);
        chk("rst_wait_ready", cmd_ready, 0);
        exp_q.delete(); iss_q.delete();
        never_done = 0;
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK); #1;
        chk("rst_release_ready", cmd_ready, 1);
        chk_en = 1;
        push(2'b01, 2'b00, 13'd21, 13'd22, 10'd3, 2'd1, acc);
        drain(50, "post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
